rv32i_bus_fabric: RTL and testbench

//  Parametrised single-master, N-slave data-bus fabric between the RV32I core data port and its slaves
//  (data memory, tbman, timer, gpio, uart). Replaces a fixed decoder plus read-mux pair.

---
 rtl/rv32i_bus_pkg.sv | 30 +++
 rtl/bus_addr_match.sv | 33 +++
 rtl/rv32i_bus_fabric.sv | 184 ++++++++++++++++++
 tb/tb_rv32i_bus_fabric.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_bus_pkg.sv
// Shared types and defaults for the RV32I data-bus fabric: FSM encoding,
// default slave map and width helpers.
package rv32i_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_e;

  localparam int DEF_NUM_SLAVES = 4;
  localparam int DEF_TIMEOUT    = 15;

  // Slave0 sits in the least significant 32 bits.
  localparam logic [32*DEF_NUM_SLAVES-1:0] DEF_BASE_ADDRS =
    {32'h8002_0000, 32'h8001_0000, 32'h8000_0000, 32'h1000_0000};
  localparam logic [32*DEF_NUM_SLAVES-1:0] DEF_ADDR_MASKS =
    {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_C000};

  localparam logic [31:0] DEF_ERR_RDATA = 32'hDEAD_BEEF;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/bus_addr_match.sv
// Combinational priority address decoder: the lowest-numbered slave whose
// base/mask window contains addr wins.
module bus_addr_match
  import rv32i_bus_pkg::*;
#(
  parameter int                          NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int                          IDX_W      = idx_width(NUM_SLAVES),
  parameter logic [32*NUM_SLAVES-1:0]    BASE_ADDRS = DEF_BASE_ADDRS,
  parameter logic [32*NUM_SLAVES-1:0]    ADDR_MASKS = DEF_ADDR_MASKS
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  logic [NUM_SLAVES-1:0] hit_vec;

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
      assign hit_vec[gi] = ((addr & ADDR_MASKS[gi*32 +: 32]) == BASE_ADDRS[gi*32 +: 32]);
    end
  endgenerate

  // Scan from the top down so the lowest matching index overwrites last.
  always_comb begin
    hit = |hit_vec;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit_vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/rv32i_bus_fabric.sv
// Single-master, N-slave data-bus fabric: registered slave request, per-slave
// ready handshake, wait-state timeout and error reporting.
module rv32i_bus_fabric
  import rv32i_bus_pkg::*;
#(
  parameter int                       NUM_SLAVES = DEF_NUM_SLAVES,
  parameter logic [32*NUM_SLAVES-1:0] BASE_ADDRS = DEF_BASE_ADDRS,
  parameter logic [32*NUM_SLAVES-1:0] ADDR_MASKS = DEF_ADDR_MASKS,
  parameter int                       TIMEOUT    = DEF_TIMEOUT,
  parameter logic [31:0]              ERR_RDATA  = DEF_ERR_RDATA
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       m_req,
  input  logic                       m_we,
  input  logic [31:0]                m_addr,
  input  logic [31:0]                m_wdata,
  input  logic [3:0]                 m_be,
  output logic [31:0]                m_rdata,
  output logic                       m_ready,
  output logic                       m_err,
  output logic [NUM_SLAVES-1:0]      s_sel,
  output logic                       s_we,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  output logic [3:0]                 s_be,
  input  logic [32*NUM_SLAVES-1:0]   s_rdata,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  output logic [7:0]                 err_cnt,
  output logic [31:0]                err_addr
);

  localparam int IDX_W = idx_width(NUM_SLAVES);
  localparam int CNT_W = cnt_width(TIMEOUT);

  bus_state_e            state_q, state_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic                  we_q, we_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic [31:0]           err_addr_q, err_addr_d;

  logic                  dec_hit;
  logic [IDX_W-1:0]      dec_idx;
  logic [31:0]           rdata_arr [NUM_SLAVES];

  bus_addr_match #(
    .NUM_SLAVES (NUM_SLAVES),
    .IDX_W      (IDX_W),
    .BASE_ADDRS (BASE_ADDRS),
    .ADDR_MASKS (ADDR_MASKS)
  ) u_addr_match (
    .addr (m_addr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_rdata
      assign rdata_arr[gi] = s_rdata[gi*32 +: 32];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (m_req) begin
          we_d    = m_we;
          addr_d  = m_addr;
          wdata_d = m_wdata;
          be_d    = m_be;
          idx_d   = dec_idx;
          if (dec_hit) begin
            sel_d          = '0;
            sel_d[dec_idx] = 1'b1;
            cnt_d          = '0;
            state_d        = ST_ACCESS;
          end else begin
            ready_d    = 1'b1;
            err_d      = 1'b1;
            rdata_d    = ERR_RDATA;
            err_addr_d = m_addr;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            state_d    = ST_RESP;
          end
        end
      end

      ST_ACCESS: begin
        // Ready is checked before the timeout so a last-moment ready still succeeds.
        if (s_ready[idx_q]) begin
          rdata_d = we_q ? 32'h0 : rdata_arr[idx_q];
          sel_d   = '0;
          ready_d = 1'b1;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          sel_d      = '0;
          ready_d    = 1'b1;
          err_d      = 1'b1;
          rdata_d    = ERR_RDATA;
          err_addr_d = addr_q;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        sel_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign m_rdata  = rdata_q;
  assign m_ready  = ready_q;
  assign m_err    = err_q;
  assign s_sel    = sel_q;
  assign s_we     = we_q;
  assign s_addr   = addr_q;
  assign s_wdata  = wdata_q;
  assign s_be     = be_q;
  assign err_cnt  = err_cnt_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_rv32i_bus_fabric.sv
// Directed bench for rv32i_bus_fabric; slave3 is remapped onto slave0's
// window to exercise overlap priority.
module tb_rv32i_bus_fabric;

  localparam int NS = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            m_req;
  logic            m_we;
  logic [31:0]     m_addr;
  logic [31:0]     m_wdata;
  logic [3:0]      m_be;
  logic [31:0]     m_rdata;
  logic            m_ready;
  logic            m_err;
  logic [NS-1:0]   s_sel;
  logic            s_we;
  logic [31:0]     s_addr;
  logic [31:0]     s_wdata;
  logic [3:0]      s_be;
  logic [32*NS-1:0] s_rdata;
  logic [NS-1:0]   s_ready;
  logic [7:0]      err_cnt;
  logic [31:0]     err_addr;

  int n_checks = 0;
  int n_fails  = 0;
  int bad;

  always #5 clk = ~clk;

  rv32i_bus_fabric #(
    .NUM_SLAVES (NS),
    .BASE_ADDRS ({32'h1000_0000, 32'h8001_0000, 32'h8000_0000, 32'h1000_0000}),
    .ADDR_MASKS ({32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_C000}),
    .TIMEOUT    (15),
    .ERR_RDATA  (32'hDEAD_BEEF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_be     (m_be),
    .m_rdata  (m_rdata),
    .m_ready  (m_ready),
    .m_err    (m_err),
    .s_sel    (s_sel),
    .s_we     (s_we),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_be     (s_be),
    .s_rdata  (s_rdata),
    .s_ready  (s_ready),
    .err_cnt  (err_cnt),
    .err_addr (err_addr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      $display("check %-16s obs=%h exp=%h ok", tag, obs, exp);
    else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    m_req   = 1'b1;
    m_we    = we;
    m_addr  = addr;
    m_wdata = wdata;
    m_be    = be;
  endtask

  initial begin
    reset   = 1'b1;
    m_req   = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_be    = '0;
    s_rdata = '0;
    s_ready = '0;
    tick();
    tick();
    chk("rst_sel",      32'(s_sel),   32'h0);
    chk("rst_ready",    32'(m_ready), 32'h0);
    chk("rst_err",      32'(m_err),   32'h0);
    chk("rst_rdata",    m_rdata,      32'h0);
    chk("rst_saddr",    s_addr,       32'h0);
    chk("rst_errcnt",   32'(err_cnt), 32'h0);
    chk("rst_erraddr",  err_addr,     32'h0);
    reset = 1'b0;
    tick();

    // 1: zero-wait read of slave0 (overlaps slave3, lower index wins)
    s_ready = 4'b1111;
    s_rdata[31:0] = 32'h1234_5678;
    start(1'b0, 32'h1000_0010, 32'h0, 4'hF);
    tick();
    chk("t1_sel_c1",   32'(s_sel),   32'h1);
    chk("t1_ready_c1", 32'(m_ready), 32'h0);
    chk("t1_saddr",    s_addr,       32'h1000_0010);
    tick();
    chk("t1_ready_c2", 32'(m_ready), 32'h1);
    chk("t1_err",      32'(m_err),   32'h0);
    chk("t1_rdata",    m_rdata,      32'h1234_5678);
    chk("t1_sel_c2",   32'(s_sel),   32'h0);
    m_req = 1'b0;
    tick();
    chk("t1_ready_c3", 32'(m_ready), 32'h0);

    // 2: write slave1 with three wait states; m_req dropped early
    s_ready = 4'b0000;
    start(1'b1, 32'h8000_0004, 32'hA5A5_0F0F, 4'b0011);
    bad = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (s_sel !== 4'b0010 || m_ready !== 1'b0) bad++;
      if (c == 1) m_req = 1'b0;
      if (c == 4) s_ready[1] = 1'b1;
    end
    chk("t2_wait_sel", 32'(bad), 32'h0);
    tick();
    chk("t2_ready_c5", 32'(m_ready), 32'h1);
    chk("t2_err",      32'(m_err),   32'h0);
    chk("t2_rdata",    m_rdata,      32'h0);
    chk("t2_sel_c5",   32'(s_sel),   32'h0);
    chk("t2_be",       32'(s_be),    32'h3);
    chk("t2_we",       32'(s_we),    32'h1);
    chk("t2_wdata",    s_wdata,      32'hA5A5_0F0F);
    s_ready = 4'b0000;
    tick();

    // 3: unmapped read
    start(1'b0, 32'h2000_0000, 32'h0, 4'hF);
    tick();
    chk("t3_ready",   32'(m_ready), 32'h1);
    chk("t3_err",     32'(m_err),   32'h1);
    chk("t3_rdata",   m_rdata,      32'hDEAD_BEEF);
    chk("t3_sel",     32'(s_sel),   32'h0);
    chk("t3_erraddr", err_addr,     32'h2000_0000);
    chk("t3_errcnt",  32'(err_cnt), 32'h1);
    m_req = 1'b0;
    tick();

    // 4: slave2 never ready -> timeout 17 cycles after request
    start(1'b0, 32'h8001_0100, 32'h0, 4'hF);
    repeat (16) tick();
    chk("t4_sel_c16",   32'(s_sel),   32'h4);
    chk("t4_ready_c16", 32'(m_ready), 32'h0);
    m_req = 1'b0;
    tick();
    chk("t4_ready_c17", 32'(m_ready), 32'h1);
    chk("t4_err_c17",   32'(m_err),   32'h1);
    chk("t4_sel_c17",   32'(s_sel),   32'h0);
    chk("t4_rdata",     m_rdata,      32'hDEAD_BEEF);
    chk("t4_erraddr",   err_addr,     32'h8001_0100);
    chk("t4_errcnt",    32'(err_cnt), 32'h2);
    tick();
    bad = 0;
    for (int r = 0; r < 300; r++) begin
      start(1'b0, 32'h8001_0200, 32'h0, 4'hF);
      repeat (16) tick();
      if (m_ready !== 1'b0) bad++;
      m_req = 1'b0;
      tick();
      if (m_ready !== 1'b1 || m_err !== 1'b1) bad++;
      tick();
    end
    chk("t4_repeat_bad", 32'(bad),     32'h0);
    chk("t4_errcnt_sat", 32'(err_cnt), 32'hFF);

    // 5a: ready arrives on the timeout cycle -> success
    s_rdata[95:64] = 32'hCAFE_F00D;
    start(1'b0, 32'h8001_0300, 32'h0, 4'hF);
    repeat (16) tick();
    s_ready[2] = 1'b1;
    m_req = 1'b0;
    tick();
    chk("t5_ready",   32'(m_ready), 32'h1);
    chk("t5_err",     32'(m_err),   32'h0);
    chk("t5_rdata",   m_rdata,      32'hCAFE_F00D);
    chk("t5_erraddr", err_addr,     32'h8001_0200);
    s_ready = 4'b0000;
    tick();

    // 5b: reset while in ACCESS aborts silently
    start(1'b0, 32'h8001_0400, 32'h0, 4'hF);
    tick();
    chk("t5b_sel_c1", 32'(s_sel), 32'h4);
    tick();
    reset = 1'b1;
    m_req = 1'b0;
    tick();
    chk("t5b_sel_rst",    32'(s_sel),   32'h0);
    chk("t5b_ready_rst",  32'(m_ready), 32'h0);
    chk("t5b_errcnt_rst", 32'(err_cnt), 32'h0);
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (m_ready !== 1'b0 || s_sel !== 4'b0000) bad++;
    end
    chk("t5b_no_ready", 32'(bad), 32'h0);

    // 6: overlap -> slave0 only; stray ready on others ignored
    s_rdata[31:0]   = 32'h0000_AAAA;
    s_rdata[127:96] = 32'h3333_3333;
    start(1'b0, 32'h1000_0020, 32'h0, 4'hF);
    tick();
    chk("t6_sel_c1", 32'(s_sel), 32'h1);
    s_ready = 4'b1110;
    tick();
    s_ready = 4'b0100;
    tick();
    chk("t6_sel_c3",   32'(s_sel),   32'h1);
    chk("t6_ready_c3", 32'(m_ready), 32'h0);
    s_ready = 4'b1001;
    m_req = 1'b0;
    tick();
    chk("t6_ready", 32'(m_ready), 32'h1);
    chk("t6_err",   32'(m_err),   32'h0);
    chk("t6_rdata", m_rdata,      32'h0000_AAAA);
    s_ready = 4'b0000;
    tick();
    start(1'b0, 32'h1000_4000, 32'h0, 4'hF);
    tick();
    chk("t6_sel3", 32'(s_sel), 32'h8);
    s_ready = 4'b1000;
    m_req = 1'b0;
    tick();
    chk("t6_ready3", 32'(m_ready), 32'h1);
    chk("t6_rdata3", m_rdata,      32'h3333_3333);
    s_ready = 4'b0000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
